// File: rtl/pipe_stage_reg_pkg.sv
// Package for the generic inter-stage pipeline register.
// Contents:
//   - exception code constants (0 means "no exception")
//   - default reset and handler pc values
//   - the per-cycle event encoding, plus the priority function that
//     turns the raw control inputs into a single event
package pipe_stage_reg_pkg;

  // Exception codes
  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Default pc values
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] HANDLER_PC_DEF = 32'h0000_4180;

  // What the stage register does on a given edge
  typedef enum logic [2:0] {
    EV_RESET = 3'd0,
    EV_REQ   = 3'd1,
    EV_CLR   = 3'd2,
    EV_LOAD  = 3'd3,
    EV_HOLD  = 3'd4
  } stage_ev_e;

  // Priority: reset > req > clr > en > hold
  function automatic stage_ev_e sel_event(input logic reset, input logic req,
                                          input logic clr, input logic en);
    if (reset)     return EV_RESET;
    else if (req)  return EV_REQ;
    else if (clr)  return EV_CLR;
    else if (en)   return EV_LOAD;
    else           return EV_HOLD;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
// Ports:
//   clk  - rising-edge clock
//   clr  - synchronous clear (highest priority)
//   inc  - count one when high
//   cnt  - current count; sticks at all-ones and never wraps
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register for the 5-stage core.
// Carries instr, pc, link address (pc8), exception code, delay-slot flag
// and a valid bit, with bubble insertion, exception merging and
// saturating stall/flush counters.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   req                   - exception/interrupt taken: flush to handler pc
//   clr                   - insert a bubble this cycle (ignores en)
//   en                    - load enable; 0 holds every field (stall)
//   in_instr/in_pc/in_exc/loc_exc/in_bd/in_valid - upstream slot
//   out_instr/out_pc/out_pc8/out_exc/out_bd/out_valid - registered slot
//   stall_cnt             - cycles spent holding (saturating)
//   flush_cnt             - cycles with req or clr (saturating)
//
// Handshake: en is the downstream ready for this stage. When en=1 and no
// higher-priority event is present the upstream slot is captured on the
// edge; when en=0 every field holds. in_valid qualifies the upstream slot
// only; it never gates the load itself.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int                 DATA_W     = 32,
  parameter int                 EXC_W      = 5,
  parameter logic [DATA_W-1:0]  RESET_PC   = DATA_W'(RESET_PC_DEF),
  parameter logic [DATA_W-1:0]  HANDLER_PC = DATA_W'(HANDLER_PC_DEF),
  parameter int                 LINK_OFF   = 8,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic [EXC_W-1:0]  in_exc,
  input  logic [EXC_W-1:0]  loc_exc,
  input  logic              in_bd,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_pc8,
  output logic [EXC_W-1:0]  out_exc,
  output logic              out_bd,
  output logic              out_valid,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  stage_ev_e         ev;
  logic [EXC_W-1:0]  exc_merged;
  logic [DATA_W-1:0] link_pc;
  logic              stall_inc;
  logic              flush_inc;

  always_comb begin
    ev         = sel_event(reset, req, clr, en);
    // Earlier stage's exception wins; invalid slots never raise one.
    exc_merged = '0;
    if (in_valid) begin
      exc_merged = (in_exc != '0) ? in_exc : loc_exc;
    end
    // Wraps modulo 2^DATA_W by construction of the sized sum.
    link_pc    = in_pc + DATA_W'(LINK_OFF);
    stall_inc  = (ev == EV_HOLD);
    flush_inc  = (ev == EV_REQ) || (ev == EV_CLR);
  end

  always_ff @(posedge clk) begin
    case (ev)
      EV_RESET: begin
        out_instr <= '0;
        out_pc    <= RESET_PC;
        out_pc8   <= '0;
        out_exc   <= '0;
        out_bd    <= 1'b0;
        out_valid <= 1'b0;
      end
      EV_REQ: begin
        out_instr <= '0;
        out_pc    <= HANDLER_PC;
        out_pc8   <= '0;
        out_exc   <= '0;
        out_bd    <= 1'b0;
        out_valid <= 1'b0;
      end
      EV_CLR: begin
        // Bubble keeps pc/bd so a later exception can still report an EPC.
        out_instr <= '0;
        out_pc    <= in_pc;
        out_pc8   <= link_pc;
        out_exc   <= '0;
        out_bd    <= in_bd;
        out_valid <= 1'b0;
      end
      EV_LOAD: begin
        out_instr <= in_instr;
        out_pc    <= in_pc;
        out_pc8   <= link_pc;
        out_exc   <= exc_merged;
        out_bd    <= in_bd;
        out_valid <= in_valid;
      end
      default: ; // EV_HOLD: every field keeps its value
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .clr (reset),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .clr (reset),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. A second instance with 4-bit counters
// shares the stimulus so counter saturation is reached in a few cycles.
module tb_pipe_stage_reg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req, clr, en;
  logic [31:0] in_instr, in_pc;
  logic [4:0]  in_exc, loc_exc;
  logic        in_bd, in_valid;

  logic [31:0] out_instr, out_pc, out_pc8;
  logic [4:0]  out_exc;
  logic        out_bd, out_valid;
  logic [15:0] stall_cnt, flush_cnt;

  logic [31:0] s_instr, s_pc, s_pc8;
  logic [4:0]  s_exc;
  logic        s_bd, s_valid;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .req(req), .clr(clr), .en(en),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .loc_exc(loc_exc),
    .in_bd(in_bd), .in_valid(in_valid),
    .out_instr(out_instr), .out_pc(out_pc), .out_pc8(out_pc8),
    .out_exc(out_exc), .out_bd(out_bd), .out_valid(out_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) dut_small (
    .clk(clk), .reset(reset), .req(req), .clr(clr), .en(en),
    .in_instr(in_instr), .in_pc(in_pc), .in_exc(in_exc), .loc_exc(loc_exc),
    .in_bd(in_bd), .in_valid(in_valid),
    .out_instr(s_instr), .out_pc(s_pc), .out_pc8(s_pc8),
    .out_exc(s_exc), .out_bd(s_bd), .out_valid(s_valid),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  // ---------------- driver tasks ----------------
  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic ctrl(input logic r, input logic q, input logic c, input logic e);
    reset = r; req = q; clr = c; en = e;
  endtask

  task automatic slot(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [4:0] exc, input logic [4:0] lexc,
                      input logic bd, input logic vld);
    in_instr = instr; in_pc = pc; in_exc = exc; loc_exc = lexc;
    in_bd = bd; in_valid = vld;
  endtask

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    slot(32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;

    // 1: reset
    tick();
    chk("rst_pc",    out_pc,    32'h3000);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc8",   out_pc8,   32'h0);
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_stall", {16'b0, stall_cnt}, 32'h0);
    chk("rst_flush", {16'b0, flush_cnt}, 32'h0);

    // 2: load
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    slot(32'h2408_0001, 32'h3010, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    chk("ld_pc",    out_pc,    32'h3010);
    chk("ld_pc8",   out_pc8,   32'h3018);
    chk("ld_instr", out_instr, 32'h2408_0001);
    chk("ld_valid", {31'b0, out_valid}, 32'h1);
    chk("ld_exc",   {27'b0, out_exc}, 32'h0);

    // 3: stall 3 cycles with changing inputs
    ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    slot(32'hDEAD_0001, 32'h5000, 5'd12, 5'd5, 1'b1, 1'b0);
    tick();
    slot(32'hDEAD_0002, 32'h5004, 5'd0, 5'd10, 1'b0, 1'b1);
    tick();
    slot(32'hDEAD_0003, 32'h5008, 5'd4, 5'd0, 1'b1, 1'b1);
    tick();
    chk("stl_pc",    out_pc,    32'h3010);
    chk("stl_pc8",   out_pc8,   32'h3018);
    chk("stl_instr", out_instr, 32'h2408_0001);
    chk("stl_valid", {31'b0, out_valid}, 32'h1);
    chk("stl_bd",    {31'b0, out_bd}, 32'h0);
    chk("stl_exc",   {27'b0, out_exc}, 32'h0);
    chk("stl_cnt",   {16'b0, stall_cnt}, 32'd3);
    chk("stl_flush", {16'b0, flush_cnt}, 32'd0);

    // 4: bubble with en=0
    ctrl(1'b0, 1'b0, 1'b1, 1'b0);
    slot(32'h1234_5678, 32'h3020, 5'd4, 5'd10, 1'b1, 1'b1);
    tick();
    chk("clr_instr", out_instr, 32'h0);
    chk("clr_valid", {31'b0, out_valid}, 32'h0);
    chk("clr_pc",    out_pc,    32'h3020);
    chk("clr_pc8",   out_pc8,   32'h3028);
    chk("clr_bd",    {31'b0, out_bd}, 32'h1);
    chk("clr_exc",   {27'b0, out_exc}, 32'h0);
    chk("clr_flush", {16'b0, flush_cnt}, 32'd1);
    chk("clr_stall", {16'b0, stall_cnt}, 32'd3);

    // 5: req beats clr, then reset beats req
    ctrl(1'b0, 1'b1, 1'b1, 1'b1);
    tick();
    chk("req_pc",    out_pc,    32'h4180);
    chk("req_pc8",   out_pc8,   32'h0);
    chk("req_bd",    {31'b0, out_bd}, 32'h0);
    chk("req_exc",   {27'b0, out_exc}, 32'h0);
    chk("req_valid", {31'b0, out_valid}, 32'h0);
    chk("req_flush", {16'b0, flush_cnt}, 32'd2);
    chk("req_stall", {16'b0, stall_cnt}, 32'd3);
    ctrl(1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rr_pc",    out_pc, 32'h3000);
    chk("rr_flush", {16'b0, flush_cnt}, 32'd0);
    chk("rr_stall", {16'b0, stall_cnt}, 32'd0);

    // 6: exception merging
    ctrl(1'b0, 1'b0, 1'b0, 1'b1);
    slot(32'h0000_0011, 32'h3040, 5'd4, 5'd10, 1'b0, 1'b1);
    tick();
    chk("exc_in",  {27'b0, out_exc}, 32'd4);
    slot(32'h0000_0022, 32'h3044, 5'd0, 5'd10, 1'b1, 1'b1);
    tick();
    chk("exc_loc", {27'b0, out_exc}, 32'd10);
    chk("exc_bd",  {31'b0, out_bd}, 32'h1);
    slot(32'h0000_0033, 32'h3048, 5'd12, 5'd5, 1'b0, 1'b0);
    tick();
    chk("exc_inv",       {27'b0, out_exc}, 32'd0);
    chk("exc_inv_instr", out_instr, 32'h0000_0033);
    chk("exc_inv_valid", {31'b0, out_valid}, 32'h0);

    // pc8 wraps modulo 2^32
    slot(32'h0000_0044, 32'hFFFF_FFFC, 5'd0, 5'd0, 1'b0, 1'b1);
    tick();
    chk("wrap_pc8", out_pc8, 32'h0000_0004);
    chk("wrap_pc",  out_pc,  32'hFFFF_FFFC);

    // Saturation on the 4-bit instance: 20 stall cycles
    ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    tick(15);
    chk("sat_stall_15", {28'b0, s_stall_cnt}, 32'hF);
    tick(5);
    chk("sat_stall_20", {28'b0, s_stall_cnt}, 32'hF);
    chk("big_stall_20", {16'b0, stall_cnt},   32'd20);
    chk("sat_hold_pc",  out_pc, 32'hFFFF_FFFC);

    // 18 flush cycles
    ctrl(1'b0, 1'b0, 1'b1, 1'b1);
    tick(18);
    chk("sat_flush",   {28'b0, s_flush_cnt}, 32'hF);
    chk("big_flush",   {16'b0, flush_cnt},   32'd18);
    chk("flush_stall", {16'b0, stall_cnt},   32'd20);

    // Reset mid-stall clears everything
    ctrl(1'b0, 1'b0, 1'b0, 1'b0);
    tick(2);
    ctrl(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid_rst_stall",  {16'b0, stall_cnt}, 32'd0);
    chk("mid_rst_flush",  {16'b0, flush_cnt}, 32'd0);
    chk("mid_rst_sstall", {28'b0, s_stall_cnt}, 32'd0);
    chk("mid_rst_pc",     out_pc, 32'h3000);
    chk("mid_rst_bd",     {31'b0, out_bd}, 32'h0);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
